// File: rtl/timer_entry_pkg.sv
// Shared definitions for the microwave timer keypad entry and BCD counter chain.
package timer_entry_pkg;

  localparam int unsigned DIGIT_W              = 4;
  localparam int unsigned BCD_MAX              = 9;
  localparam int unsigned DEFAULT_MAX_DIGITS   = 4;
  localparam int unsigned DEFAULT_MAX_SEC_TENS = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_LOAD  = 2'd2,
    ST_START = 2'd3
  } entry_state_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] code);
    return code <= DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_shift_buffer.sv
// Four-digit BCD entry register; new digits enter at sec_ones and shift toward min_tens.
module bcd_shift_buffer
  import timer_entry_pkg::*;
(
  input  logic               clock,
  input  logic               clear,
  input  logic               flush,
  input  logic               shift_en,
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] min_tens
);

  always_ff @(posedge clock) begin
    if (clear || flush) begin
      sec_ones <= '0;
      sec_tens <= '0;
      min_ones <= '0;
      min_tens <= '0;
    end else if (shift_en) begin
      min_tens <= min_ones;
      min_ones <= sec_tens;
      sec_tens <= sec_ones;
      sec_ones <= digit_in;
    end
  end

endmodule

// File: rtl/timer_entry.sv
// Keypad-side writer: collects MM:SS digits, validates START, then drives loadn and start_pulse.
module timer_entry
  import timer_entry_pkg::*;
#(
  parameter int unsigned MAX_DIGITS   = DEFAULT_MAX_DIGITS,
  parameter int unsigned MAX_SEC_TENS = DEFAULT_MAX_SEC_TENS
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_code,
  input  logic               start_key,
  input  logic               stop_key,
  input  logic               timer_running,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] min_tens,
  output logic               loadn,
  output logic               start_pulse,
  output logic               entry_active,
  output logic               error
);

  localparam int unsigned CNT_W = 3;

  entry_state_t     state, state_nxt;
  logic [CNT_W-1:0] digit_cnt, cnt_nxt;
  logic             error_nxt;
  logic             in_keypad, stop_evt, start_evt, digit_evt, start_ok, flush;

  bcd_shift_buffer u_buffer (
    .clock    (clock),
    .clear    (clear),
    .flush    (flush),
    .shift_en (digit_evt),
    .digit_in (key_code),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens)
  );

  // Event decode with priority stop > start > digit; lower-priority strobes are dropped.
  always_comb begin
    in_keypad = (state == ST_IDLE) || (state == ST_ENTRY);
    stop_evt  = in_keypad && stop_key;
    start_evt = (state == ST_ENTRY) && start_key && !stop_key && !timer_running;
    start_ok  = (|{min_tens, min_ones, sec_tens, sec_ones}) &&
                (sec_tens <= DIGIT_W'(MAX_SEC_TENS));
    digit_evt = in_keypad && key_valid && !stop_key && !start_key && !timer_running &&
                is_bcd(key_code) && (digit_cnt < CNT_W'(MAX_DIGITS));
    flush     = stop_evt || (state == ST_START);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = digit_cnt;
    error_nxt = error;
    unique case (state)
      ST_IDLE: begin
        if (stop_evt) begin
          cnt_nxt   = '0;
          error_nxt = 1'b0;
        end else if (digit_evt) begin
          state_nxt = ST_ENTRY;
          cnt_nxt   = digit_cnt + CNT_W'(1);
          error_nxt = 1'b0;
        end
      end
      ST_ENTRY: begin
        if (stop_evt) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          error_nxt = 1'b0;
        end else if (start_evt) begin
          if (start_ok) begin
            state_nxt = ST_LOAD;
            error_nxt = 1'b0;
          end else begin
            error_nxt = 1'b1;
          end
        end else if (digit_evt) begin
          cnt_nxt   = digit_cnt + CNT_W'(1);
          error_nxt = 1'b0;
        end
      end
      ST_LOAD:  state_nxt = ST_START;
      ST_START: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are registered copies of the next-state decode, so they track the state register exactly.
  always_ff @(posedge clock) begin
    if (clear) begin
      state        <= ST_IDLE;
      digit_cnt    <= '0;
      loadn        <= 1'b1;
      start_pulse  <= 1'b0;
      entry_active <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_nxt;
      digit_cnt    <= cnt_nxt;
      loadn        <= (state_nxt != ST_LOAD);
      start_pulse  <= (state_nxt == ST_START);
      entry_active <= (cnt_nxt != '0);
      error        <= error_nxt;
    end
  end

endmodule
